// File: rtl/weight_mem_pkg.sv
// -----------------------------------------------------------------------------
// weight_mem_pkg
// Shared types and constants for the weight streaming memory.
//   state_t     : burst engine states (IDLE, RUN, DRAIN)
//   SKID_DEPTH  : entries in the output skid FIFO
//   addr_width(): clog2-based address width, never below 1 bit
// -----------------------------------------------------------------------------
package weight_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int unsigned SKID_DEPTH = 2;

   // Width needed to index 'depth' entries; a single entry still gets 1 bit.
   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/weight_skid_fifo.sv
// -----------------------------------------------------------------------------
// weight_skid_fifo
// Two-entry valid/ready FIFO with registered output, width-parametrised.
//   i_clk, i_rst     : clock, synchronous active-high reset (flushes contents)
//   i_valid, i_data  : write side; a push is accepted while not full, or when
//                      full and the head is popped in the same cycle
//   o_valid, o_data  : head of the FIFO, driven straight from a register
//   i_ready          : consumer accepts the head
//   o_count          : current occupancy, for credit-based upstream flow control
// -----------------------------------------------------------------------------
module weight_skid_fifo
   import weight_mem_pkg::*;
#(
   parameter  int unsigned W  = 8,
   localparam int unsigned CW = addr_width(SKID_DEPTH + 1)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_valid,
   input  logic [W-1:0]  i_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [W-1:0]  o_data,
   output logic [CW-1:0] o_count
);

   logic [W-1:0]  r_d0;
   logic [W-1:0]  r_d1;
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic          w_push;

   assign o_valid = (r_count != '0);
   assign o_data  = r_d0;
   assign o_count = r_count;
   assign w_pop   = o_valid & i_ready;
   assign w_push  = i_valid & ((r_count != CW'(SKID_DEPTH)) | w_pop);

   // Head (r_d0) only changes on a pop or when the FIFO is empty, so the
   // output stays stable while the consumer stalls.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_d0    <= '0;
         r_d1    <= '0;
         r_count <= '0;
      end else begin
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
         if (w_pop) begin
            r_d0 <= r_d1;
         end
         if (w_push) begin
            if ((r_count == '0) || (w_pop && (r_count == CW'(1)))) begin
               r_d0 <= i_data;
            end else begin
               r_d1 <= i_data;
            end
         end
      end
   end

endmodule

// File: rtl/weight_stream_bram.sv
// -----------------------------------------------------------------------------
// weight_stream_bram
// One neuron's weight vector in inferred block RAM, with a host write port and
// a burst read engine streaming LEN words from BASE over valid/ready.
// Optional feature macro: WEIGHT_PARITY_EN (even parity per word, o_par_err).
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_we/i_waddr/i_di   : host write port (addresses >= DEPTH ignored)
//   i_start/i_base/i_len: burst request (single-cycle pulse), ignored while busy
//   o_do/o_do_valid/i_do_ready/o_do_last : streamed weights with backpressure
//   o_busy              : burst in progress
//   o_done              : one-cycle pulse after the last word is accepted
//   o_par_err           : (WEIGHT_PARITY_EN only) parity error, sticky to START
// -----------------------------------------------------------------------------
module weight_stream_bram
   import weight_mem_pkg::*;
#(
   parameter  int unsigned DATA_W    = 16,
   parameter  int unsigned DEPTH     = 28,
   parameter               INIT_FILE = "",
   localparam int unsigned AW        = addr_width(DEPTH)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_we,
   input  logic [AW-1:0]     i_waddr,
   input  logic [DATA_W-1:0] i_di,
   input  logic              i_start,
   input  logic [AW-1:0]     i_base,
   input  logic [AW:0]       i_len,
   output logic [DATA_W-1:0] o_do,
   output logic              o_do_valid,
   input  logic              i_do_ready,
   output logic              o_do_last,
   output logic              o_busy,
`ifdef WEIGHT_PARITY_EN
   output logic              o_par_err,
`endif
   output logic              o_done
);

`ifdef WEIGHT_PARITY_EN
   localparam int unsigned PAR_W = 1;
`else
   localparam int unsigned PAR_W = 0;
`endif
   localparam int unsigned RAM_W  = DATA_W + PAR_W;
   localparam int unsigned FIFO_W = DATA_W + 1 + PAR_W;
   localparam int unsigned CW     = addr_width(SKID_DEPTH + 1);

   logic [RAM_W-1:0]  r_mem [DEPTH];
   logic [RAM_W-1:0]  r_rd_data;
   logic              r_inflight;
   logic              r_rd_last;
   state_t            r_state;
   logic [AW-1:0]     r_rd_addr;
   logic [AW:0]       r_rem;
   logic              r_busy;
   logic              r_done;

   logic [RAM_W-1:0]  w_wr_word;
   logic              w_start_ok;
   logic              w_issue_idle;
   logic              w_issue_run;
   logic              w_issue;
   logic              w_issue_last;
   logic              w_credit_ok;
   logic [AW-1:0]     w_rd_addr;
   logic              w_pop;
   logic [FIFO_W-1:0] w_fifo_in;
   logic [FIFO_W-1:0] w_head;
   logic [CW-1:0]     w_fifo_count;
   logic              w_head_last;

   function automatic logic [AW-1:0] f_next_addr(input logic [AW-1:0] a);
      return (a == AW'(DEPTH - 1)) ? '0 : a + AW'(1);
   endfunction

`ifdef WEIGHT_PARITY_EN
   assign w_wr_word = {^i_di, i_di};
`else
   assign w_wr_word = i_di;
`endif

   // The first read goes out in the START cycle straight from i_base so the
   // first word reaches o_do two cycles after START.
   assign w_start_ok   = (r_state == IDLE) & i_start;
   assign w_issue_idle = w_start_ok & (i_len != '0);
   assign w_pop        = o_do_valid & i_do_ready;
   // Occupancy counted after this cycle's pop keeps one word per cycle flowing
   // while never letting an in-flight read overrun the two FIFO entries.
   assign w_credit_ok  = (3'(w_fifo_count) + 3'(r_inflight) - 3'(w_pop)) < 3'(SKID_DEPTH);
   assign w_issue_run  = (r_state == RUN) & (r_rem != '0) & w_credit_ok;
   assign w_issue      = w_issue_idle | w_issue_run;
   assign w_rd_addr    = (r_state == IDLE) ? i_base : r_rd_addr;
   assign w_issue_last = (r_state == IDLE) ? (i_len == (AW+1)'(1)) : (r_rem == (AW+1)'(1));

   // Block RAM: write port plus registered read; same-address access is read-first.
   always_ff @(posedge i_clk) begin
      if (i_we && ({1'b0, i_waddr} < (AW+1)'(DEPTH))) begin
         r_mem[i_waddr] <= w_wr_word;
      end
      if (w_issue) begin
         r_rd_data <= r_mem[w_rd_addr];
      end
   end

   // Read pipeline tag: data valid next cycle, with its last-word flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_inflight <= 1'b0;
         r_rd_last  <= 1'b0;
      end else begin
         r_inflight <= w_issue;
         if (w_issue) begin
            r_rd_last <= w_issue_last;
         end
      end
   end

`ifdef WEIGHT_PARITY_EN
   logic w_head_perr;
   logic r_perr_sticky;

   assign w_fifo_in   = {^r_rd_data, r_rd_last, r_rd_data[DATA_W-1:0]};
   assign w_head_perr = w_head[DATA_W+1];
   assign o_par_err   = r_perr_sticky | (o_do_valid & w_head_perr);

   // Parity error stays asserted once a bad word has been delivered.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_perr_sticky <= 1'b0;
      end else if (w_start_ok) begin
         r_perr_sticky <= 1'b0;
      end else if (w_pop && w_head_perr) begin
         r_perr_sticky <= 1'b1;
      end
   end
`else
   assign w_fifo_in = {r_rd_last, r_rd_data};
`endif

   weight_skid_fifo #(
      .W (FIFO_W)
   ) u_skid (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (r_inflight),
      .i_data  (w_fifo_in),
      .o_valid (o_do_valid),
      .i_ready (i_do_ready),
      .o_data  (w_head),
      .o_count (w_fifo_count)
   );

   assign w_head_last = w_head[DATA_W];
   assign o_do        = w_head[DATA_W-1:0];
   assign o_do_last   = w_head_last;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

   // Burst engine.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_rd_addr <= '0;
         r_rem     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_start_ok) begin
                  if (i_len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_rd_addr <= f_next_addr(i_base);
                     r_rem     <= i_len - (AW+1)'(1);
                     r_busy    <= 1'b1;
                     r_state   <= RUN;
                  end
               end
            end
            RUN: begin
               if (r_rem == '0) begin
                  r_state <= DRAIN;
               end else if (w_issue_run) begin
                  r_rd_addr <= f_next_addr(r_rd_addr);
                  r_rem     <= r_rem - (AW+1)'(1);
               end
            end
            DRAIN: begin
               if ((w_pop && w_head_last) || ((w_fifo_count == '0) && !r_inflight)) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_weight_stream_bram.sv
// -----------------------------------------------------------------------------
// tb_weight_stream_bram
// Directed bench for weight_stream_bram (DEPTH=28, DATA_W=16). Burst vectors
// come from a table with hand-computed first/last words; per-word data is
// checked against a bench-side copy of the RAM contents.
// Build with WEIGHT_PARITY_EN to also exercise o_par_err.
// -----------------------------------------------------------------------------
module tb_weight_stream_bram;

   localparam int DEPTH = 28;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_we = 1'b0;
   logic [4:0]  i_waddr = '0;
   logic [15:0] i_di = '0;
   logic        i_start = 1'b0;
   logic [4:0]  i_base = '0;
   logic [5:0]  i_len = '0;
   logic        i_do_ready = 1'b0;
   logic [15:0] o_do;
   logic        o_do_valid;
   logic        o_do_last;
   logic        o_busy;
   logic        o_done;
`ifdef WEIGHT_PARITY_EN
   logic        o_par_err;
`endif

   int checks = 0;
   int errors = 0;
   int exp_mem [DEPTH];

   always #5 clk = ~clk;

   weight_stream_bram #(
      .DATA_W (16),
      .DEPTH  (DEPTH)
   ) dut (
      .i_clk      (clk),
      .i_rst      (i_rst),
      .i_we       (i_we),
      .i_waddr    (i_waddr),
      .i_di       (i_di),
      .i_start    (i_start),
      .i_base     (i_base),
      .i_len      (i_len),
      .o_do       (o_do),
      .o_do_valid (o_do_valid),
      .i_do_ready (i_do_ready),
      .o_do_last  (o_do_last),
      .o_busy     (o_busy),
`ifdef WEIGHT_PARITY_EN
      .o_par_err  (o_par_err),
`endif
      .o_done     (o_done)
   );

   typedef struct {
      int base;
      int len;
      int pct;        // DO_READY duty in percent
      int restart;    // cycle of an extra START while busy, -1 none
      int wr_cyc;     // cycle of a host write, -1 none
      int wr_addr;
      int wr_data;
      int rst_after;  // assert reset after this many words, -1 none
      int exp_first;
      int exp_last;
      bit chk_lat;
   } vec_t;

   vec_t vecs [9];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int  snap [DEPTH];
      int  got = 0;
      int  first_cyc = -1;
      int  last_cyc = -1;
      int  done_cyc = -1;
      int  first_w = -1;
      int  last_w = -1;
      int  pv = 0;
      int  pl = 0;
      bit  stall = 1'b0;
      bit  rd;
      for (int i = 0; i < DEPTH; i++) snap[i] = exp_mem[i];
      for (int cyc = 0; cyc < 400; cyc++) begin
         i_start = 1'b0;
         i_we    = 1'b0;
         if (o_done) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == 0) begin
            i_start = 1'b1;
            i_base  = 5'(v.base);
            i_len   = 6'(v.len);
         end
         if (cyc == 1) chk("busy_rise", int'(o_busy), 1);
         if (cyc == v.restart) begin
            i_start = 1'b1;
            i_base  = 5'd20;
            i_len   = 6'd3;
         end
         if (cyc == v.wr_cyc) begin
            i_we    = 1'b1;
            i_waddr = 5'(v.wr_addr);
            i_di    = 16'(v.wr_data);
         end
         if (stall) begin
            chk("stall_valid", int'(o_do_valid), 1);
            chk("stall_do", int'(o_do), pv);
            chk("stall_last", int'(o_do_last), pl);
         end
         if (v.rst_after >= 0 && got == v.rst_after) begin
            i_rst      = 1'b1;
            i_do_ready = 1'b0;
            tick();
            i_rst   = 1'b0;
            i_start = 1'b0;
            i_we    = 1'b0;
            chk("rst_valid", int'(o_do_valid), 0);
            chk("rst_busy", int'(o_busy), 0);
            repeat (4) begin
               chk("rst_no_done", int'(o_done), 0);
               tick();
            end
            chk("rst_idle_valid", int'(o_do_valid), 0);
            return;
         end
         rd = ($urandom_range(99) < v.pct);
         i_do_ready = rd;
         if (o_do_valid && first_cyc < 0) first_cyc = cyc;
         if (o_do_valid && rd) begin
            chk("data", int'(o_do), snap[(v.base + got) % DEPTH]);
            chk("last_flag", int'(o_do_last), int'(got == v.len - 1));
            if (got == 0) first_w = int'(o_do);
            if (got == v.len - 1) begin
               last_w   = int'(o_do);
               last_cyc = cyc;
            end
            got++;
         end
         stall = o_do_valid && !rd;
         pv    = int'(o_do);
         pl    = int'(o_do_last);
         tick();
      end
      chk("done_seen", int'(done_cyc >= 0), 1);
      chk("word_count", got, v.len);
      chk("done_timing", done_cyc, last_cyc + 1);
      if (v.chk_lat) chk("first_latency", first_cyc, 2);
      chk("first_word", first_w, v.exp_first);
      chk("last_word", last_w, v.exp_last);
      chk("busy_fall", int'(o_busy), 0);
      i_do_ready = 1'b0;
      tick();
      chk("done_pulse", int'(o_done), 0);
      chk("idle_valid", int'(o_do_valid), 0);
   endtask

   initial begin
      //            base len pct rst wcyc wadr wdata rsta first last lat
      vecs[0] = '{   0, 28, 100, -1,  -1,  0,     0, -1,     0,    81, 1};
      vecs[1] = '{  25,  6, 100, -1,  -1,  0,     0, -1,    75,     6, 1};
      vecs[2] = '{   0, 20,  30, -1,  -1,  0,     0, -1,     0,    57, 0};
      vecs[3] = '{   3,  5, 100,  3,  -1,  0,     0, -1,     9,    21, 1};
      vecs[4] = '{   0, 10, 100, -1,   4,  4, 48879, -1,     0,    27, 1};
      vecs[5] = '{   4,  1, 100, -1,  -1,  0,     0, -1, 48879, 48879, 1};
      vecs[6] = '{  27,  2,  50, -1,  -1,  0,     0, -1,    81,     0, 0};
      vecs[7] = '{   0, 20, 100, -1,  -1,  0,     0,  5,     0,     0, 0};
      vecs[8] = '{   1,  3, 100, -1,  -1,  0,     0, -1,     3,     9, 1};

      repeat (3) tick();
      i_rst = 1'b0;
      chk("reset_do", int'(o_do), 0);
      chk("reset_valid", int'(o_do_valid), 0);
      chk("reset_last", int'(o_do_last), 0);
      chk("reset_busy", int'(o_busy), 0);
      chk("reset_done", int'(o_done), 0);

      // Fill RAM with addr*3, then two out-of-range writes that must be ignored.
      for (int a = 0; a < DEPTH; a++) begin
         i_we    = 1'b1;
         i_waddr = 5'(a);
         i_di    = 16'(a * 3);
         exp_mem[a] = a * 3;
         tick();
      end
      i_waddr = 5'd28; i_di = 16'hDEAD; tick();
      i_waddr = 5'd31; i_di = 16'hDEAD; tick();
      i_we = 1'b0;
      tick();

      for (int k = 0; k < 9; k++) begin
         run_vec(vecs[k]);
         if (vecs[k].wr_cyc >= 0) exp_mem[vecs[k].wr_addr] = vecs[k].wr_data;
         tick();
      end

      // Zero-length burst: DONE next cycle, no data.
      i_start = 1'b1; i_base = 5'd7; i_len = 6'd0; i_do_ready = 1'b1;
      tick();
      i_start = 1'b0;
      chk("len0_done", int'(o_done), 1);
      chk("len0_busy", int'(o_busy), 0);
      chk("len0_valid", int'(o_do_valid), 0);
      tick();
      chk("len0_done_pulse", int'(o_done), 0);
      repeat (3) begin
         chk("len0_no_data", int'(o_do_valid), 0);
         tick();
      end

`ifdef WEIGHT_PARITY_EN
      // Corrupt one stored bit behind the parity and stream that word.
      dut.r_mem[2] = dut.r_mem[2] ^ 17'h00001;
      i_do_ready = 1'b0;
      i_start = 1'b1; i_base = 5'd2; i_len = 6'd1;
      tick();
      i_start = 1'b0;
      tick();
      chk("par_valid", int'(o_do_valid), 1);
      chk("par_err", int'(o_par_err), 1);
      i_do_ready = 1'b1;
      tick();
      chk("par_sticky", int'(o_par_err), 1);
      repeat (3) tick();
      i_start = 1'b1; i_base = 5'd3; i_len = 6'd1;
      tick();
      i_start = 1'b0;
      chk("par_clear", int'(o_par_err), 0);
      repeat (4) tick();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
